// File: rtl/mult_acc_seq_pkg.sv
// Shared definitions for the sequential multiply/divide pair: FSM state
// encoding and a constant-width helper.
package mult_acc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OPERATE = 2'b01,
    LAST    = 2'b10,
    DONE    = 2'b11
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_acc_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half, then shift the combined {ph, pl} right by one bit.
module mult_acc_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] ph_in,
  input  logic [W-1:0] pl_in,
  input  logic [W-1:0] m_in,
  output logic [W:0]   ph_out,
  output logic [W-1:0] pl_out
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, ph_in} + (pl_in[0] ? {1'b0, m_in} : '0);
    // {sum, pl} >> 1: the carry lands in ph, sum[0] becomes the new pl MSB.
    {ph_out, pl_out} = {1'b0, sum, pl_in[W-1:1]};
  end

endmodule

// File: rtl/mult_acc_seq.sv
// Sequential shift-add multiplier with post-add: prod = mplr * mcnd + addend,
// one result every W+3 cycles using a start/ready/done handshake.
module mult_acc_seq
  import mult_acc_seq_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned CBIT = clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcnd,
  input  logic [W-1:0]   mplr,
  input  logic [W-1:0]   addend,
  output logic           ready,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic           ovf
);

  state_e          state_q, state_d;
  logic [W:0]      ph_q, ph_d;
  logic [W-1:0]    pl_q, pl_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    a_q, a_d;
  logic [CBIT-1:0] n_q, n_d;

  logic [W:0]      step_ph;
  logic [W-1:0]    step_pl;
  logic [CBIT-1:0] n_dec;
  logic [2*W:0]    post_sum;

  mult_acc_step #(.W(W)) u_step (
    .ph_in  (ph_q[W-1:0]),
    .pl_in  (pl_q),
    .m_in   (m_q),
    .ph_out (step_ph),
    .pl_out (step_pl)
  );

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    pl_d     = pl_q;
    m_d      = m_q;
    a_d      = a_q;
    n_d      = n_q;
    n_dec    = n_q - CBIT'(1);
    post_sum = {ph_q, pl_q} + (2*W+1)'(a_q);
    ready    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          ph_d    = '0;
          pl_d    = mplr;
          m_d     = mcnd;
          a_d     = addend;
          n_d     = CBIT'(W);
          state_d = OPERATE;
        end
      end
      OPERATE: begin
        ph_d = step_ph;
        pl_d = step_pl;
        n_d  = n_dec;
        if (n_dec == '0) state_d = LAST;
      end
      LAST: begin
        // ph[W] is zero after the final shift, so the full add never overflows 2W bits.
        ph_d    = post_sum[2*W:W];
        pl_d    = post_sum[W-1:0];
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      pl_q    <= '0;
      m_q     <= '0;
      a_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      m_q     <= m_d;
      a_q     <= a_d;
      n_q     <= n_d;
    end
  end

  assign prod = {ph_q[W-1:0], pl_q};
  assign ovf  = |prod[2*W-1:W];

endmodule

// File: tb/tb_mult_acc_seq.sv
// Randomized self-checking bench for mult_acc_seq against an arithmetic model.
module tb_mult_acc_seq;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcnd;
  logic [W-1:0]   mplr;
  logic [W-1:0]   addend;
  logic           ready;
  logic           done;
  logic [2*W-1:0] prod;
  logic           ovf;

  int unsigned n_checks;
  int unsigned n_fail;

  mult_acc_seq #(.W(W), .CBIT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcnd   (mcnd),
    .mplr   (mplr),
    .addend (addend),
    .ready  (ready),
    .done   (done),
    .prod   (prod),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, handshake and result against exp.
  task automatic run_op(input string tag, input logic [W-1:0] mc, input logic [W-1:0] mp,
                        input logic [W-1:0] ad, input int unsigned exp, input bit disturb);
    int unsigned lat;
    int unsigned rdy_hi;
    bit          seen;
    int unsigned waited;
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " idle_wait"}, 32'(ready), 32'd1);
    mcnd   = mc;
    mplr   = mp;
    addend = ad;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat    = 0;
    rdy_hi = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (disturb && i == 3) begin
        start  = 1'b1;
        mcnd   = W'($urandom);
        mplr   = W'($urandom);
        addend = W'($urandom);
      end
      if (disturb && i == 4) start = 1'b0;
      if (ready) rdy_hi++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_eq({tag, " latency"}, lat, W + 2);
    check_eq({tag, " ready_low"}, rdy_hi, 0);
    check_eq({tag, " prod"}, 32'(prod), exp);
    check_eq({tag, " ovf"}, 32'(ovf), 32'(exp > 255));
  endtask

  initial begin
    int unsigned dvnd, dvsr, q, r, mc, mp, ad;
    int unsigned done_cnt, last_done, seen_done;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    mcnd     = '0;
    mplr     = '0;
    addend   = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset prod", 32'(prod), 0);
    check_eq("reset ovf", 32'(ovf), 0);
    check_eq("reset done", 32'(done), 0);
    check_eq("reset ready", 32'(ready), 1);
    rst = 1'b1;

    run_op("basic", 8'd17, 8'd13, 8'd5, 226, 1'b0);
    run_op("max", 8'd255, 8'd255, 8'd255, 65280, 1'b0);
    run_op("mcnd0", 8'd0, 8'd200, 8'd7, 7, 1'b0);
    run_op("mplr0", 8'd9, 8'd0, 8'd0, 0, 1'b0);
    run_op("rt200_7", 8'd7, 8'd28, 8'd4, 200, 1'b0);

    // Divider round trip: quotient*divisor+remainder must rebuild the dividend.
    for (int i = 0; i < 200; i++) begin
      dvnd = $urandom_range(0, 255);
      dvsr = $urandom_range(1, 255);
      q = dvnd / dvsr;
      r = dvnd % dvsr;
      run_op("roundtrip", W'(dvsr), W'(q), W'(r), dvnd, 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      mc = $urandom_range(0, 255);
      mp = $urandom_range(0, 255);
      ad = $urandom_range(0, 255);
      run_op("random", W'(mc), W'(mp), W'(ad), mc * mp + ad, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      mc = $urandom_range(0, 255);
      mp = $urandom_range(0, 255);
      ad = $urandom_range(0, 255);
      run_op("disturb", W'(mc), W'(mp), W'(ad), mc * mp + ad, 1'b1);
    end

    // Start held high continuously: one result every W+3 cycles.
    @(negedge clk);
    while (!ready) @(negedge clk);
    mcnd = 8'd11; mplr = 8'd23; addend = 8'd9;
    start = 1'b1;
    done_cnt = 0;
    last_done = 0;
    for (int i = 1; i <= 60 && done_cnt < 4; i++) begin
      @(negedge clk);
      if (done) begin
        check_eq("held prod", 32'(prod), 11 * 23 + 9);
        if (done_cnt > 0) check_eq("held interval", i - last_done, W + 3);
        last_done = i;
        done_cnt++;
      end
    end
    start = 1'b0;
    check_eq("held count", done_cnt, 4);

    // Reset in the middle of an operation.
    @(negedge clk);
    while (!ready) @(negedge clk);
    mcnd = 8'd200; mplr = 8'd201; addend = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre-abort prod nonzero", 32'(prod != 0), 1);
    rst = 1'b0;
    #1;
    check_eq("abort prod", 32'(prod), 0);
    check_eq("abort done", 32'(done), 0);
    check_eq("abort ready", 32'(ready), 1);
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done++;
      check_eq("abort hold ready", 32'(ready), 1);
    end
    rst = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check_eq("abort no done", seen_done, 0);
    run_op("after_abort", 8'd3, 8'd4, 8'd1, 13, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
